vmem_fill_ctrl: RTL and testbench
=================================

Name: vmem_fill_ctrl

Overview:
- Memory-mapped rectangle-fill engine and write-port arbiter sitting in front of the vmem write port.
- Lets the CPU start a hardware fill of a W×H rectangle with a 3-bit colour while CPU stores to vmem keep flowing.
- CPU stores always win the port. The engine writes in the cycles the CPU leaves free.
- Sits between the dbus decode (vmem and fill-register strobes) and vmem.

Parameters:
LCD_W, 240, visible columns; engine writes with x >= LCD_W are suppressed
LCD_H, 240, visible rows; engine writes with y >= LCD_H are suppressed

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
cpu_we_i  in  1  CPU vmem store strobe
cpu_addr_i  in  16  CPU vmem address {y[7:0],x[7:0]}
cpu_wdata_i  in  3  CPU pixel {r,g,b}
cfg_we_i  in  1  fill-register write strobe
cfg_addr_i  in  4  register byte offset (0x0,0x4,0x8,0xC)
cfg_wdata_i  in  32  register write data
cfg_rdata_o  out  32  register read data, registered
vmem_we_o  out  1  write strobe to vmem
vmem_waddr_o  out  16  write address to vmem
vmem_wdata_o  out  3  write data to vmem
busy_o  out  1  fill in progress
done_o  out  1  one-cycle pulse when a fill completes or is aborted

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - All registers cleared; state=IDLE.
  - vmem_we_o=0, vmem_waddr_o=0, vmem_wdata_o=0, cfg_rdata_o=0, busy_o=0, done_o=0.
  - Reset during RUN abandons the fill. No further engine writes and no done_o pulse.
- Registers:
  - 0x0 CTRL. Write: bit0=START, bit1=ABORT. Read: {30'b0, done_sticky, busy}.
  - 0x4 ORG = {16'b0, y0[7:0], x0[7:0]}.
  - 0x8 SIZE = {16'b0, h[7:0], w[7:0]}.
  - 0xC COLOR = {29'b0, c[2:0]}.
  - Reads are registered. cfg_rdata_o at N+1 reflects cfg_addr_i at N.
  - done_sticky is set on completion or abort and cleared by a START write.
- Shadowing: ORG, SIZE and COLOR are copied into working registers at START. Writes to them during RUN affect only the next fill.
- FSM IDLE:
  - START (ABORT=0) with w!=0 and h!=0 → RUN. Cursor (cx,cy)=(x0,y0).
  - START with w==0 or h==0 → stay IDLE and pulse done_o next cycle.
  - START while RUN is ignored.
- FSM RUN:
  - Each cycle with cpu_we_i=0 is an engine slot.
  - In a slot the engine issues (cx,cy) with colour c. The write is suppressed if cx>=LCD_W or cy>=LCD_H, but the slot is still consumed.
  - Cursor order is raster: cx increments. At cx==x0+w-1, cx←x0 and cy increments.
  - After the slot for (x0+w-1, y0+h-1): → IDLE and done_o pulses in the same cycle the last write appears on vmem_we_o.
  - Cursor arithmetic is 8-bit modulo 256. Coordinates wrapping past 255 become small values and are written if visible.
- ABORT: a CTRL write with bit1=1 forces IDLE next cycle and pulses done_o once (only if it was in RUN). ABORT beats START in the same write.
- Arbitration:
  - Fixed priority, CPU first. A CPU store is never stalled or dropped.
  - The engine may starve indefinitely under continuous CPU stores.
- Output path:
  - Both paths register into vmem_*_o with exactly 1-cycle latency.
  - A CPU store at cycle N appears at N+1. Ordering between CPU and engine writes is preserved.
- busy_o = (state==RUN), registered, asserted the cycle after START.
- Uncontended fill: first write at START+2 (state registered, then output registered). Total w·h consecutive write cycles.

Decomposition:
- Shared package / config.vh constants:
  - Register offsets FILL_CTRL=0x0, FILL_ORG=0x4, FILL_SIZE=0x8, FILL_COLOR=0xC.
  - CTRL bit positions.
  - State encodings IDLE/RUN.
  - LCD_W/LCD_H defaults.
- One natural sub-module, fill_cursor: holds cx/cy, x0/w/y0/h, step enable. Outputs the current coordinate and a last-pixel flag.
- Arbitration, register file and FSM stay in vmem_fill_ctrl.

Test Plan:
- ORG=0x0A05, SIZE=0x0203, COLOR=5, START, no CPU traffic → 6 writes to 0x0A05,0x0A06,0x0A07,0x0B05,0x0B06,0x0B07 with data 5 on consecutive cycles; done_o once, with the last write; CTRL read = 0b10.
- Same fill with cpu_we_i high on two cycles mid-fill (addr 0x0000, data 7) → the CPU writes appear 1 cycle later and interleave. The engine still completes all 6 pixels in order, 8 cycles total.
- ORG=0x00EE (x0=238), SIZE=0x0104 → writes at x=238,239 only. Slots for x=240,241 are suppressed; done_o after 4 slots.
- SIZE=0x0000, START → no vmem writes; done_o pulses once; busy_o stays 0.
- Fill of 16×16 started, ABORT written after 5 engine writes → at most one more write; then IDLE, done_o once; a later START runs a fresh fill from ORG.
- rst_ni low for one cycle mid-fill → vmem_we_o=0 the next cycle, busy_o=0, no done_o; register reads return 0.

Source files
------------

// File: rtl/vmem_fill_ctrl_pkg.sv
// Shared constants and types for the vmem rectangle-fill engine and write-port arbiter.
package vmem_fill_ctrl_pkg;

   localparam int unsigned LCD_W = 240;
   localparam int unsigned LCD_H = 240;

   localparam logic [3:0] FILL_CTRL  = 4'h0;
   localparam logic [3:0] FILL_ORG   = 4'h4;
   localparam logic [3:0] FILL_SIZE  = 4'h8;
   localparam logic [3:0] FILL_COLOR = 4'hC;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_ABORT = 1;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

endpackage

// File: rtl/vmem_fill_ctrl_if.sv
// dbus-side bundle: CPU vmem store strobe plus the fill-register access port.
interface vmem_fill_ctrl_if;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [2:0]  cpu_wdata;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;

   modport master (
      output cpu_we, cpu_addr, cpu_wdata, cfg_we, cfg_addr, cfg_wdata,
      input  cfg_rdata
   );

   modport slave (
      input  cpu_we, cpu_addr, cpu_wdata, cfg_we, cfg_addr, cfg_wdata,
      output cfg_rdata
   );
endinterface

// File: rtl/vmem_fill_ctrl_fill_cursor.sv
// Raster cursor for the fill engine: latches origin/size at load, steps (cx,cy) per engine slot.
module vmem_fill_ctrl_fill_cursor (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [15:0] org_i,
   input  logic [15:0] size_i,
   output logic [7:0]  x_o,
   output logic [7:0]  y_o,
   output logic        last_o
);

   logic [7:0] cx_q, cx_d, cy_q, cy_d;
   logic [7:0] x0_q, y0_q, w_q, h_q;
   logic [7:0] x_end, y_end;
   logic       row_end;

   // All cursor arithmetic is modulo 256, so rectangles may wrap past column/row 255.
   assign x_end   = x0_q + w_q - 8'd1;
   assign y_end   = y0_q + h_q - 8'd1;
   assign row_end = (cx_q == x_end);
   assign last_o  = row_end && (cy_q == y_end);
   assign x_o     = cx_q;
   assign y_o     = cy_q;

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (load_i) begin
         cx_d = org_i[7:0];
         cy_d = org_i[15:8];
      end else if (step_i) begin
         if (row_end) begin
            cx_d = x0_q;
            cy_d = cy_q + 8'd1;
         end else begin
            cx_d = cx_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cx_q <= '0;
         cy_q <= '0;
         x0_q <= '0;
         y0_q <= '0;
         w_q  <= '0;
         h_q  <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
         if (load_i) begin
            x0_q <= org_i[7:0];
            y0_q <= org_i[15:8];
            w_q  <= size_i[7:0];
            h_q  <= size_i[15:8];
         end
      end
   end

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine with fixed-priority vmem write arbitration; CPU stores always win.
module vmem_fill_ctrl
   import vmem_fill_ctrl_pkg::*;
#(
   parameter int unsigned LcdW = LCD_W,
   parameter int unsigned LcdH = LCD_H
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   vmem_fill_ctrl_if.slave        bus_io,
   output logic                   vmem_we_o,
   output logic [15:0]            vmem_waddr_o,
   output logic [2:0]             vmem_wdata_o,
   output logic                   busy_o,
   output logic                   done_o
);

   state_e      state_q, state_d;
   logic [15:0] org_q, size_q;
   logic [2:0]  color_q, fill_color_q;
   logic        done_q, done_d, sticky_q, sticky_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q, we_d;
   logic [15:0] waddr_q, waddr_d;
   logic [2:0]  wdata_q, wdata_d;
   logic        ctrl_wr, start_req, abort_req, load, slot, last, visible, eng_wr;
   logic [7:0]  cx, cy;
   logic        unused_wdata;

   assign unused_wdata = ^bus_io.cfg_wdata[31:16];

   assign ctrl_wr   = bus_io.cfg_we && (bus_io.cfg_addr == FILL_CTRL);
   assign start_req = ctrl_wr && bus_io.cfg_wdata[CTRL_START] && !bus_io.cfg_wdata[CTRL_ABORT];
   assign abort_req = ctrl_wr && bus_io.cfg_wdata[CTRL_ABORT];

   vmem_fill_ctrl_fill_cursor u_cursor (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load),
      .step_i (slot),
      .org_i  (org_q),
      .size_i (size_q),
      .x_o    (cx),
      .y_o    (cy),
      .last_o (last)
   );

   // Off-screen slots are still consumed so the raster order stays fixed.
   assign visible = (32'(cx) < LcdW) && (32'(cy) < LcdH);
   assign eng_wr  = slot && visible;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      load    = 1'b0;
      slot    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_req) begin
               if ((size_q[7:0] != 8'd0) && (size_q[15:8] != 8'd0)) begin
                  state_d = StRun;
                  load    = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            slot = !bus_io.cpu_we;
            if (abort_req || (slot && last)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sticky_d = sticky_q;
      if (done_d) begin
         sticky_d = 1'b1;
      end else if (start_req && (state_q == StIdle)) begin
         sticky_d = 1'b0;
      end

      rdata_d = '0;
      case (bus_io.cfg_addr)
         FILL_CTRL:  rdata_d = {30'b0, sticky_q, state_q == StRun};
         FILL_ORG:   rdata_d = {16'b0, org_q};
         FILL_SIZE:  rdata_d = {16'b0, size_q};
         FILL_COLOR: rdata_d = {29'b0, color_q};
         default:    rdata_d = '0;
      endcase

      we_d    = bus_io.cpu_we || eng_wr;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (bus_io.cpu_we) begin
         waddr_d = bus_io.cpu_addr;
         wdata_d = bus_io.cpu_wdata;
      end else if (eng_wr) begin
         waddr_d = {cy, cx};
         wdata_d = fill_color_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         org_q        <= '0;
         size_q       <= '0;
         color_q      <= '0;
         fill_color_q <= '0;
         done_q       <= 1'b0;
         sticky_q     <= 1'b0;
         rdata_q      <= '0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         sticky_q <= sticky_d;
         rdata_q  <= rdata_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         if (load) fill_color_q <= color_q;
         if (bus_io.cfg_we) begin
            if (bus_io.cfg_addr == FILL_ORG)   org_q   <= bus_io.cfg_wdata[15:0];
            if (bus_io.cfg_addr == FILL_SIZE)  size_q  <= bus_io.cfg_wdata[15:0];
            if (bus_io.cfg_addr == FILL_COLOR) color_q <= bus_io.cfg_wdata[2:0];
         end
      end
   end

   assign bus_io.cfg_rdata = rdata_q;
   assign vmem_we_o        = we_q;
   assign vmem_waddr_o     = waddr_q;
   assign vmem_wdata_o     = wdata_q;
   assign busy_o           = (state_q == StRun);
   assign done_o           = done_q;

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Directed bench for vmem_fill_ctrl: fills, CPU interleave, clipping, zero size, abort, reset.
module tb_vmem_fill_ctrl;
   import vmem_fill_ctrl_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        vmem_we_o;
   logic [15:0] vmem_waddr_o;
   logic [2:0]  vmem_wdata_o;
   logic        busy_o;
   logic        done_o;
   int          checks   = 0;
   int          failures = 0;

   vmem_fill_ctrl_if bus ();

   vmem_fill_ctrl dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus_io       (bus),
      .vmem_we_o    (vmem_we_o),
      .vmem_waddr_o (vmem_waddr_o),
      .vmem_wdata_o (vmem_wdata_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we    = 1'b0;
      bus.cfg_wdata = '0;
   endtask

   task automatic test_reset();
      rst_ni        = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = FILL_CTRL;
      bus.cfg_wdata = '0;
      tick();
      tick();
      checks++;
      if ({vmem_we_o, vmem_waddr_o, vmem_wdata_o, busy_o, done_o, bus.cfg_rdata} !== 54'd0) begin
         failures++;
         $display("FAIL reset_state got we=%b a=%h d=%0d busy=%b done=%b rd=%h exp all zero",
                  vmem_we_o, vmem_waddr_o, vmem_wdata_o, busy_o, done_o, bus.cfg_rdata);
      end
      rst_ni = 1'b1;
      tick();
      checks++;
      if ({vmem_we_o, busy_o, done_o} !== 3'b000) begin
         failures++;
         $display("FAIL post_reset_idle got we=%b busy=%b done=%b exp 000",
                  vmem_we_o, busy_o, done_o);
      end
   endtask

   task automatic test_regs();
      logic [3:0]  ra [4] = '{FILL_ORG, FILL_SIZE, FILL_COLOR, FILL_CTRL};
      logic [31:0] rv [4] = '{32'h0A05, 32'h0203, 32'h5, 32'h0};
      cfg_write(FILL_ORG, 32'hFFFF_0A05);
      cfg_write(FILL_SIZE, 32'h0000_0203);
      cfg_write(FILL_COLOR, 32'h0000_0005);
      for (int i = 0; i < 4; i++) begin
         bus.cfg_addr = ra[i];
         tick();
         checks++;
         if (bus.cfg_rdata !== rv[i]) begin
            failures++;
            $display("FAIL reg_read%0d got %h exp %h", i, bus.cfg_rdata, rv[i]);
         end
      end
   endtask

   task automatic test_fill_basic();
      logic [15:0] ea [6] = '{16'h0A05, 16'h0A06, 16'h0A07, 16'h0B05, 16'h0B06, 16'h0B07};
      cfg_write(FILL_CTRL, 32'h1);
      checks++;
      if ({vmem_we_o, busy_o, done_o} !== 3'b010) begin
         failures++;
         $display("FAIL basic_start1 got we=%b busy=%b done=%b exp 010",
                  vmem_we_o, busy_o, done_o);
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o} !==
             {1'b1, ea[i], 3'd5, i == 5}) begin
            failures++;
            $display("FAIL basic_px%0d got we=%b a=%h d=%0d done=%b exp a=%h d=5 done=%b",
                     i, vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o, ea[i], i == 5);
         end
         tick();
      end
      checks++;
      if ({vmem_we_o, busy_o, done_o, bus.cfg_rdata} !== {3'b000, 32'h2}) begin
         failures++;
         $display("FAIL basic_end got we=%b busy=%b done=%b rd=%h exp 000 rd=2",
                  vmem_we_o, busy_o, done_o, bus.cfg_rdata);
      end
   endtask

   task automatic test_cpu_interleave();
      logic [15:0] ea [8] = '{16'h0A05, 16'h0A06, 16'h0000, 16'h0000,
                              16'h0A07, 16'h0B05, 16'h0B06, 16'h0B07};
      logic [2:0]  ed [8] = '{3'd5, 3'd5, 3'd7, 3'd7, 3'd5, 3'd5, 3'd5, 3'd5};
      cfg_write(FILL_CTRL, 32'h1);
      bus.cpu_addr  = 16'h0000;
      bus.cpu_wdata = 3'd7;
      for (int i = 0; i < 9; i++) begin
         bus.cpu_we = (i == 2) || (i == 3);
         if (i > 0) begin
            checks++;
            if ({vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o} !==
                {1'b1, ea[i-1], ed[i-1], i == 8}) begin
               failures++;
               $display("FAIL mix_cyc%0d got we=%b a=%h d=%0d done=%b exp a=%h d=%0d done=%b",
                        i - 1, vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o,
                        ea[i-1], ed[i-1], i == 8);
            end
         end
         tick();
      end
      checks++;
      if ({vmem_we_o, busy_o, done_o} !== 3'b000) begin
         failures++;
         $display("FAIL mix_end got we=%b busy=%b done=%b exp 000", vmem_we_o, busy_o, done_o);
      end
   endtask

   task automatic test_edge_clip();
      cfg_write(FILL_ORG, 32'h00EE);
      cfg_write(FILL_SIZE, 32'h0104);
      cfg_write(FILL_COLOR, 32'h3);
      cfg_write(FILL_CTRL, 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (i < 2) begin
            if ({vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o} !==
                {1'b1, 16'h00EE + 16'(i), 3'd3, 1'b0}) begin
               failures++;
               $display("FAIL clip_px%0d got we=%b a=%h d=%0d done=%b exp a=%h d=3 done=0",
                        i, vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o, 16'h00EE + 16'(i));
            end
         end else if ({vmem_we_o, busy_o, done_o} !== {1'b0, i == 2, i == 3}) begin
            failures++;
            $display("FAIL clip_slot%0d got we=%b busy=%b done=%b exp 0%b%b",
                     i, vmem_we_o, busy_o, done_o, i == 2, i == 3);
         end
      end
   endtask

   task automatic test_zero_size();
      cfg_write(FILL_SIZE, 32'h0);
      bus.cfg_addr = FILL_CTRL;
      cfg_write(FILL_CTRL, 32'h1);
      checks++;
      if ({vmem_we_o, busy_o, done_o} !== 3'b001) begin
         failures++;
         $display("FAIL zero_pulse got we=%b busy=%b done=%b exp 001", vmem_we_o, busy_o, done_o);
      end
      tick();
      checks++;
      if ({vmem_we_o, busy_o, done_o, bus.cfg_rdata} !== {3'b000, 32'h2}) begin
         failures++;
         $display("FAIL zero_after got we=%b busy=%b done=%b rd=%h exp 000 rd=2",
                  vmem_we_o, busy_o, done_o, bus.cfg_rdata);
      end
   endtask

   task automatic test_abort_restart();
      cfg_write(FILL_ORG, 32'h1020);
      cfg_write(FILL_SIZE, 32'h1010);
      cfg_write(FILL_COLOR, 32'h6);
      cfg_write(FILL_CTRL, 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o} !==
             {1'b1, 16'h1020 + 16'(i), 3'd6, 1'b0}) begin
            failures++;
            $display("FAIL abort_px%0d got we=%b a=%h d=%0d done=%b exp a=%h d=6 done=0",
                     i, vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o, 16'h1020 + 16'(i));
         end
      end
      // START set alongside ABORT must lose.
      cfg_write(FILL_CTRL, 32'h3);
      checks++;
      if ({vmem_we_o, vmem_waddr_o, busy_o, done_o} !== {1'b1, 16'h1025, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL abort_edge got we=%b a=%h busy=%b done=%b exp we=1 a=1025 busy=0 done=1",
                  vmem_we_o, vmem_waddr_o, busy_o, done_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({vmem_we_o, busy_o, done_o} !== 3'b000) begin
            failures++;
            $display("FAIL abort_quiet%0d got we=%b busy=%b done=%b exp 000",
                     i, vmem_we_o, busy_o, done_o);
         end
      end
      cfg_write(FILL_SIZE, 32'h0102);
      cfg_write(FILL_CTRL, 32'h1);
      cfg_write(FILL_COLOR, 32'h1);
      checks++;
      if ({vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o} !== {1'b1, 16'h1020, 3'd6, 1'b0}) begin
         failures++;
         $display("FAIL restart_px0 got we=%b a=%h d=%0d done=%b exp a=1020 d=6 done=0",
                  vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o);
      end
      cfg_write(FILL_SIZE, 32'h0101);
      checks++;
      if ({vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o} !== {1'b1, 16'h1021, 3'd6, 1'b1}) begin
         failures++;
         $display("FAIL restart_px1 got we=%b a=%h d=%0d done=%b exp a=1021 d=6 done=1",
                  vmem_we_o, vmem_waddr_o, vmem_wdata_o, done_o);
      end
   endtask

   task automatic test_reset_midfill();
      cfg_write(FILL_SIZE, 32'h1010);
      cfg_write(FILL_CTRL, 32'h1);
      tick();
      tick();
      rst_ni       = 1'b0;
      bus.cfg_addr = FILL_ORG;
      tick();
      rst_ni = 1'b1;
      checks++;
      if ({vmem_we_o, busy_o, done_o, bus.cfg_rdata} !== {3'b000, 32'h0}) begin
         failures++;
         $display("FAIL rst_mid got we=%b busy=%b done=%b rd=%h exp 000 rd=0",
                  vmem_we_o, busy_o, done_o, bus.cfg_rdata);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({vmem_we_o, busy_o, done_o, bus.cfg_rdata} !== {3'b000, 32'h0}) begin
            failures++;
            $display("FAIL rst_after%0d got we=%b busy=%b done=%b rd=%h exp 000 rd=0",
                     i, vmem_we_o, busy_o, done_o, bus.cfg_rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_fill_basic();
      test_cpu_interleave();
      test_edge_clip();
      test_zero_size();
      test_abort_restart();
      test_reset_midfill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
